// File: rtl/cake_stack_tracker.sv
// -----------------------------------------------------------------------------
// cake_stack_tracker
//
// Game-state block feeding the sidebar renderer. It draws a random recipe of
// 2..5 cake layers topped by a cherry, builds the caught stack from catch
// events, compares the two when the stack is closed, and keeps a saturating
// score of matched rounds.
//
// Stacks are 18 bits wide with layer k at [3k+2:3k]. The bottom layer is at
// [2:0], and 3'b000 means an empty layer.
//
// Parameters
//   HOLD_CYCLES  cycles the finished round stays on screen (>= 1)
//   SEED         non-zero reset value of the 16-bit LFSR
//
// Ports
//   clock         system clock
//   resetn        synchronous, active-low reset
//   catch_valid   one-cycle pulse: an item landed on the plate
//   catch_colour  3'b001..3'b110 cake, 3'b111 cherry, 3'b000 ignored
//   sidebar_done  sidebar idle; output stacks may change safely
//   cake_caught   caught stack as presented to the sidebar
//   recipe        target stack as presented to the sidebar
//   ld_sidebar    recipe valid (every state except GEN and CLEAR)
//   score         matched rounds, saturating at 255
//   match / miss  one-cycle result pulses, the cycle after CHECK
//
// Build option
//   CAKE_STACK_SHADOW_EN  when defined, the output stacks are shadow registers
//                         that copy the internal stacks only while
//                         sidebar_done is high.
// -----------------------------------------------------------------------------
module cake_stack_tracker #(
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        catch_valid,
  input  logic [2:0]  catch_colour,
  input  logic        sidebar_done,
  output logic [17:0] cake_caught,
  output logic [17:0] recipe,
  output logic        ld_sidebar,
  output logic [7:0]  score,
  output logic        match,
  output logic        miss
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_GEN   = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SHOW  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  state_t           state_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [2:0]       gen_idx_q;
  logic [2:0]       n_q;
  logic [17:0]      stack_q;
  logic [17:0]      recipe_q;
  logic [2:0]       depth_q;
  logic [7:0]       score_q;
  logic             match_q;
  logic             miss_q;
  logic             ld_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [2:0]       gen_layer_s;
  logic             catch_ok_s;
  logic             close_s;
  logic             stacks_synced_s;

  // Cake colours must avoid the empty code and the cherry code.
  function automatic logic [2:0] cake_colour(input logic [2:0] raw);
    logic [2:0] col;
    case (raw)
      3'b000:  col = 3'b001;
      3'b111:  col = 3'b110;
      default: col = raw;
    endcase
    return col;
  endfunction

  // Replace one 3-bit layer of an 18-bit stack.
  function automatic logic [17:0] put_layer(input logic [17:0] stack,
                                            input logic [2:0]  idx,
                                            input logic [2:0]  colour);
    logic [17:0] res;
    res = stack;
    for (int k = 0; k < 6; k++) begin
      if (idx == 3'(k)) begin
        res[3*k +: 3] = colour;
      end
    end
    return res;
  endfunction

  // Galois LFSR next value: shift right, fold the mask in when bit 0 falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end else begin
      lfsr_d = lfsr_d;
    end
  end

  // Recipe layer produced by the current GEN step.
  always_comb begin
    gen_layer_s = 3'b000;
    if (gen_idx_q < n_q) begin
      gen_layer_s = cake_colour(lfsr_q[4:2]);
    end else if (gen_idx_q == n_q) begin
      gen_layer_s = 3'b111;
    end else begin
      gen_layer_s = 3'b000;
    end
  end

  assign catch_ok_s = catch_valid && (catch_colour != 3'b000);
  // A cherry closes the stack, as does the sixth layer (depth 5 -> 6).
  assign close_s    = (catch_colour == 3'b111) || (depth_q == 3'd5);

  // Round sequencer: recipe generation, catching, checking, display hold.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_GEN;
      lfsr_q     <= SEED;
      gen_idx_q  <= 3'd0;
      n_q        <= 3'd2 + {1'b0, SEED[1:0]};
      stack_q    <= 18'd0;
      recipe_q   <= 18'd0;
      depth_q    <= 3'd0;
      score_q    <= 8'd0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
      ld_q       <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
      case (state_q)
        ST_GEN: begin
          recipe_q <= put_layer(recipe_q, gen_idx_q, gen_layer_s);
          if (gen_idx_q == 3'd5) begin
            gen_idx_q <= 3'd0;
            state_q   <= ST_PLAY;
            ld_q      <= 1'b1;
          end else begin
            gen_idx_q <= gen_idx_q + 3'd1;
            ld_q      <= 1'b0;
          end
        end
        ST_PLAY: begin
          ld_q <= 1'b1;
          if (catch_ok_s) begin
            stack_q <= put_layer(stack_q, depth_q, catch_colour);
            depth_q <= depth_q + 3'd1;
            if (close_s) begin
              state_q <= ST_CHECK;
            end else begin
              state_q <= ST_PLAY;
            end
          end else begin
            state_q <= ST_PLAY;
          end
        end
        ST_CHECK: begin
          ld_q       <= 1'b1;
          hold_cnt_q <= HOLD_LOAD;
          state_q    <= ST_SHOW;
          if (stack_q == recipe_q) begin
            match_q <= 1'b1;
            if (score_q != 8'd255) begin
              score_q <= score_q + 8'd1;
            end else begin
              score_q <= score_q;
            end
          end else begin
            miss_q <= 1'b1;
          end
        end
        ST_SHOW: begin
          // Leave only once the final stacks have reached the sidebar.
          if (hold_cnt_q == '0) begin
            if (stacks_synced_s) begin
              state_q <= ST_CLEAR;
              ld_q    <= 1'b0;
            end else begin
              ld_q    <= 1'b1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
            ld_q       <= 1'b1;
          end
        end
        ST_CLEAR: begin
          stack_q   <= 18'd0;
          depth_q   <= 3'd0;
          n_q       <= 3'd2 + {1'b0, lfsr_q[1:0]};
          gen_idx_q <= 3'd0;
          state_q   <= ST_GEN;
          ld_q      <= 1'b0;
        end
        default: begin
          gen_idx_q <= 3'd0;
          state_q   <= ST_GEN;
          ld_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAKE_STACK_SHADOW_EN
  logic [17:0] caught_out_q;
  logic [17:0] recipe_out_q;

  // Shadow copies follow the internal stacks only while the sidebar is idle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      caught_out_q <= 18'd0;
      recipe_out_q <= 18'd0;
    end else if (sidebar_done) begin
      caught_out_q <= stack_q;
      recipe_out_q <= recipe_q;
    end else begin
      caught_out_q <= caught_out_q;
      recipe_out_q <= recipe_out_q;
    end
  end

  assign stacks_synced_s = (caught_out_q == stack_q) && (recipe_out_q == recipe_q);
  assign cake_caught     = caught_out_q;
  assign recipe          = recipe_out_q;
`else
  logic sidebar_unused_s;
  assign sidebar_unused_s = sidebar_done;
  assign stacks_synced_s  = 1'b1;
  assign cake_caught      = stack_q;
  assign recipe           = recipe_q;
`endif

  assign ld_sidebar = ld_q;
  assign score      = score_q;
  assign match      = match_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_cake_stack_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cake_stack_tracker (HOLD_CYCLES = 4).
// Inputs change on the falling edge and outputs are sampled there as well.
// The reference model derives the LFSR history, the recipes, the caught
// stacks and the score from the round timeline, using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_cake_stack_tracker;

  localparam int          HOLD = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock;
  logic        resetn;
  logic        catch_valid;
  logic [2:0]  catch_colour;
  logic        sidebar_done;
  logic [17:0] cake_caught;
  logic [17:0] recipe;
  logic        ld_sidebar;
  logic [7:0]  score;
  logic        match;
  logic        miss;

  int n_compared;
  int n_mismatched;

  // Model state.
  int          cyc;
  logic [15:0] ml;
  logic [15:0] hist [0:16383];
  int          g0;
  int          n_cur;
  int          score_m;

  cake_stack_tracker #(.HOLD_CYCLES(HOLD), .SEED(SEED)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .catch_valid  (catch_valid),
    .catch_colour (catch_colour),
    .sidebar_done (sidebar_done),
    .cake_caught  (cake_caught),
    .recipe       (recipe),
    .ld_sidebar   (ld_sidebar),
    .score        (score),
    .match        (match),
    .miss         (miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // LFSR history: hist[c] is the LFSR value seen at the c-th clock edge after reset.
  always @(posedge clock) begin
    if (!resetn) begin
      cyc <= 0;
      ml  <= SEED;
    end else begin
      hist[cyc] <= ml;
      cyc       <= cyc + 1;
      ml        <= lfsr_step(ml);
    end
  end

  function automatic logic [17:0] exp_recipe(input int start, input int n);
    logic [17:0] r;
    logic [15:0] v;
    int c;
    r = 18'd0;
    for (int i = 0; i < 6; i++) begin
      v = hist[start + i];
      c = int'(v[4:2]);
      if (c == 0) c = 1;
      if (c == 7) c = 6;
      if (i < n) r = r | (18'(c) << (3 * i));
      else if (i == n) r = r | (18'd7 << (3 * i));
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic junk();
    catch_valid  = 1'($urandom_range(0, 1));
    catch_colour = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    // A catch during the reset cycle must be overridden by the reset.
    catch_valid  = 1'b1;
    catch_colour = 3'd5;
    resetn       = 1'b0;
    tick();
    resetn       = 1'b1;
    catch_valid  = 1'b0;
    g0      = 0;
    n_cur   = 2 + int'(SEED[1:0]);
    score_m = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_compared++; if (cake_caught !== 18'd0) begin n_mismatched++; $display("FAIL %s_caught: got %o want 0", tag, cake_caught); end
    n_compared++; if (recipe !== 18'd0) begin n_mismatched++; $display("FAIL %s_recipe: got %o want 0", tag, recipe); end
    n_compared++; if (ld_sidebar !== 1'b0) begin n_mismatched++; $display("FAIL %s_ld: got %b want 0", tag, ld_sidebar); end
    n_compared++; if (score !== 8'd0) begin n_mismatched++; $display("FAIL %s_score: got %0d want 0", tag, score); end
    n_compared++; if ({match, miss} !== 2'b00) begin n_mismatched++; $display("FAIL %s_pulses: got %b want 00", tag, {match, miss}); end
  endtask

  // mode 0: replay recipe, 1: early cherry, 2: six 010 catches, 3: random
  task automatic run_round(input int mode);
    logic [17:0] er, mstk;
    int cols[$];
    int c, tclose, idle;
    logic exp_match;
    while (cyc < g0 + 6) begin junk(); tick(); end
    catch_valid = 1'b0;
    er = exp_recipe(g0, n_cur);
    n_compared++; if (cake_caught !== 18'd0) begin n_mismatched++; $display("FAIL play_entry_caught: got %o want 0", cake_caught); end
    n_compared++; if (ld_sidebar !== 1'b1) begin n_mismatched++; $display("FAIL play_entry_ld: got %b want 1", ld_sidebar); end
    cols.delete();
    case (mode)
      0: for (int i = 0; i <= n_cur; i++) cols.push_back(int'(er[3*i +: 3]));
      1: cols.push_back(7);
      2: for (int i = 0; i < 6; i++) cols.push_back(2);
      default: begin
        do begin c = $urandom_range(1, 7); cols.push_back(c); end
        while (c != 7 && cols.size() < 6);
      end
    endcase
    mstk = 18'd0;
    tclose = 0;
    for (int j = 0; j < cols.size(); j++) begin
      idle = (mode == 3) ? $urandom_range(0, 2) : 0;
      repeat (idle) begin
        catch_valid  = 1'($urandom_range(0, 1));
        catch_colour = 3'd0;
        tick();
      end
      catch_valid  = 1'b1;
      catch_colour = 3'(cols[j]);
      tclose = cyc;
      tick();
      catch_valid = 1'b0;
      mstk = mstk | (18'(cols[j]) << (3 * j));
`ifndef CAKE_STACK_SHADOW_EN
      n_compared++; if (cake_caught !== mstk) begin n_mismatched++; $display("FAIL catch_stack: got %o want %o", cake_caught, mstk); end
`endif
    end
    // A catch during CHECK must not write a further layer.
    catch_valid  = 1'b1;
    catch_colour = 3'd3;
    tick();
    catch_valid  = 1'b0;
    exp_match = (mstk == er);
    if (exp_match && score_m < 255) score_m++;
    n_compared++; if (match !== exp_match) begin n_mismatched++; $display("FAIL round_match: got %b want %b", match, exp_match); end
    n_compared++; if (miss !== !exp_match) begin n_mismatched++; $display("FAIL round_miss: got %b want %b", miss, !exp_match); end
    n_compared++; if (score !== 8'(score_m)) begin n_mismatched++; $display("FAIL round_score: got %0d want %0d", score, score_m); end
    n_compared++; if (recipe !== er) begin n_mismatched++; $display("FAIL round_recipe: got %o want %o", recipe, er); end
    n_compared++; if (cake_caught !== mstk) begin n_mismatched++; $display("FAIL round_caught: got %o want %o", cake_caught, mstk); end
    junk(); tick();
    n_compared++; if ({match, miss} !== 2'b00) begin n_mismatched++; $display("FAIL pulse_width: got %b want 00", {match, miss}); end
    while (cyc < tclose + 1 + HOLD) begin junk(); tick(); end
    n_compared++; if (ld_sidebar !== 1'b1) begin n_mismatched++; $display("FAIL show_ld: got %b want 1", ld_sidebar); end
    n_compared++; if (cake_caught !== mstk) begin n_mismatched++; $display("FAIL show_caught: got %o want %o", cake_caught, mstk); end
    junk(); tick();
    n_compared++; if (ld_sidebar !== 1'b0) begin n_mismatched++; $display("FAIL clear_ld: got %b want 0", ld_sidebar); end
    junk(); tick();
    n_cur = 2 + int'(hist[tclose + 2 + HOLD][1:0]);
    g0    = tclose + 3 + HOLD;
    junk(); tick();
    catch_valid = 1'b0;
    n_compared++; if (cake_caught !== 18'd0) begin n_mismatched++; $display("FAIL regen_caught: got %o want 0", cake_caught); end
  endtask

  task automatic test_reset();
    logic [2:0] lay;
    sidebar_done = 1'b1;
    do_reset();
    check_reset_outputs("reset");
    while (cyc < 6) begin junk(); tick(); end
    catch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lay = recipe[3*i +: 3];
      n_compared++; if (lay == 3'd0 || lay == 3'd7) begin n_mismatched++; $display("FAIL reset_layer%0d: got %o want 1..6", i, lay); end
    end
    n_compared++; if (recipe[11:9] !== 3'd7) begin n_mismatched++; $display("FAIL reset_cherry: got %o want 7", recipe[11:9]); end
    n_compared++; if (recipe[17:12] !== 6'd0) begin n_mismatched++; $display("FAIL reset_top: got %o want 0", recipe[17:12]); end
    n_compared++; if (recipe !== exp_recipe(0, 3)) begin n_mismatched++; $display("FAIL reset_recipe: got %o want %o", recipe, exp_recipe(0, 3)); end
    n_compared++; if (ld_sidebar !== 1'b1) begin n_mismatched++; $display("FAIL reset_ld: got %b want 1", ld_sidebar); end
  endtask

  task automatic test_early_cherry();
    run_round(1);
    n_compared++; if (score !== 8'd0) begin n_mismatched++; $display("FAIL cherry_score: got %0d want 0", score); end
  endtask

  task automatic test_overflow();
    run_round(2);
  endtask

  task automatic test_matching_round();
    run_round(0);
    n_compared++; if (score !== 8'd1) begin n_mismatched++; $display("FAIL match_score: got %0d want 1", score); end
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 20; r++) run_round(($urandom_range(0, 3) == 0) ? 0 : 3);
  endtask

`ifdef CAKE_STACK_SHADOW_EN
  task automatic test_shadow();
    logic [17:0] er;
    logic exp_match;
    int tclose, x;
    while (cyc < g0 + 7) tick();
    er = exp_recipe(g0, n_cur);
    sidebar_done = 1'b0;
    catch_valid = 1'b1; catch_colour = 3'd3; tick(); catch_valid = 1'b0;
    repeat (3) tick();
    n_compared++; if (cake_caught !== 18'd0) begin n_mismatched++; $display("FAIL shadow_hold: got %o want 0", cake_caught); end
    sidebar_done = 1'b1;
    tick();
    n_compared++; if (cake_caught !== 18'o000003) begin n_mismatched++; $display("FAIL shadow_copy: got %o want 000003", cake_caught); end
    sidebar_done = 1'b0;
    catch_valid = 1'b1; catch_colour = 3'd7; tclose = cyc; tick(); catch_valid = 1'b0;
    tick();
    exp_match = (er == 18'o000073);
    if (exp_match && score_m < 255) score_m++;
    n_compared++; if (miss !== !exp_match) begin n_mismatched++; $display("FAIL shadow_miss: got %b want %b", miss, !exp_match); end
    while (cyc < tclose + 1 + HOLD + 6) tick();
    n_compared++; if (ld_sidebar !== 1'b1) begin n_mismatched++; $display("FAIL shadow_show_stall: got %b want 1", ld_sidebar); end
    n_compared++; if (cake_caught !== 18'o000003) begin n_mismatched++; $display("FAIL shadow_stale: got %o want 000003", cake_caught); end
    sidebar_done = 1'b1;
    x = cyc;
    tick(); tick();
    n_compared++; if (ld_sidebar !== 1'b0) begin n_mismatched++; $display("FAIL shadow_exit: got %b want 0", ld_sidebar); end
    n_compared++; if (cake_caught !== 18'o000073) begin n_mismatched++; $display("FAIL shadow_final: got %o want 000073", cake_caught); end
    tick();
    n_cur = 2 + int'(hist[x + 2][1:0]);
    g0    = x + 3;
    tick();
    n_compared++; if (cake_caught !== 18'd0) begin n_mismatched++; $display("FAIL shadow_clear: got %o want 0", cake_caught); end
  endtask
`endif

  task automatic test_reset_mid_play();
    logic [17:0] mstk;
    while (cyc < g0 + 6) tick();
    mstk = 18'd0;
    for (int j = 0; j < 2; j++) begin
      catch_valid  = 1'b1;
      catch_colour = 3'($urandom_range(1, 6));
      mstk = mstk | (18'(catch_colour) << (3 * j));
      tick();
    end
    catch_valid = 1'b0;
    tick();
    n_compared++; if (cake_caught !== mstk) begin n_mismatched++; $display("FAIL midplay_before: got %o want %o", cake_caught, mstk); end
    do_reset();
    check_reset_outputs("midplay");
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 256; r++) run_round(0);
    n_compared++; if (score !== 8'd255) begin n_mismatched++; $display("FAIL saturation: got %0d want 255", score); end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    catch_valid  = 1'b0;
    catch_colour = 3'd0;
    sidebar_done = 1'b1;
    tick();
    test_reset();
    test_early_cherry();
    test_overflow();
    test_matching_round();
    test_random_rounds();
`ifdef CAKE_STACK_SHADOW_EN
    test_shadow();
`endif
    test_reset_mid_play();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
